// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage; drives 1-cycle-latency RAM (ram_read_address/ram_dout), 2-entry prefetch queue to decode (out_valid/out_ready/out_instr/out_pc), redirect via redirect_valid/redirect_pc
module instr_fetch #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] ram_read_address,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc
);
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
  logic [ADDR_WIDTH-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [DATA_WIDTH-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
  logic [1:0] count_q, count_d, lvl;
  logic inflight_q, inflight_d, pop, push, issue;
  logic [2:0] occ;
  assign out_valid = (count_q != 2'd0) & ~redirect_valid;
  assign out_instr = instr0_q;
  assign out_pc = pc0_q;
  assign pop = out_valid & out_ready;
  assign push = inflight_q & ~redirect_valid;
  assign occ = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = ~reset & (redirect_valid | (occ < 3'd2));
  assign ram_read_address = redirect_valid ? redirect_pc : fetch_pc_q;
  assign lvl = count_q - {1'b0, pop};
  always_comb begin
    inflight_d = issue;
    inflight_pc_d = issue ? ram_read_address : inflight_pc_q;
    fetch_pc_d = issue ? ram_read_address + 1'b1 : fetch_pc_q;
    pc0_d = (push && lvl == 2'd0) ? inflight_pc_q : pop ? pc1_q : pc0_q;
    instr0_d = (push && lvl == 2'd0) ? ram_dout : pop ? instr1_q : instr0_q;
    pc1_d = (push && lvl == 2'd1) ? inflight_pc_q : pc1_q;
    instr1_d = (push && lvl == 2'd1) ? ram_dout : instr1_q;
    count_d = redirect_valid ? 2'd0 : lvl + {1'b0, push};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      inflight_pc_q <= '0;
      count_q <= 2'd0;
      pc0_q <= '0;
      instr0_q <= '0;
      pc1_q <= '0;
      instr1_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q <= count_d;
      pc0_q <= pc0_d;
      instr0_q <= instr0_d;
      pc1_q <= pc1_d;
      instr1_q <= instr1_d;
    end
  end
  no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && count_q == 2'd2 && !pop));
endmodule
